// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: capture FSM encoding, drop counter width and level-width helper
package uart_rx_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cap_state_e;

    localparam int DROP_COUNT_W = 8;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO; storage is not reset, only pointers and level
module uart_rx_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          data_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [level_w(DEPTH)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok, pop_ok;

    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && !empty_o;
    // a pop on a full FIFO frees the slot the push lands in
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
            level_q  <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: acknowledges receiver bytes, buffers them, and drives RTS, overrun and IRQ
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int RTS_THRESHOLD = FIFO_DEPTH - 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           rx_valid,
    input  logic [PAYLOAD_BITS-1:0]        rx_data,
    input  logic                           rx_rts,
    output logic                           rx_read,
    output logic                           uart_rts,
    output logic [PAYLOAD_BITS-1:0]        data_out,
    output logic                           data_avail,
    input  logic                           data_pop,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           overrun,
    output logic [DROP_COUNT_W-1:0]        drop_count,
    input  logic                           clr_overrun,
    input  logic                           irq_en,
    output logic                           irq
);

    localparam int LW = level_w(FIFO_DEPTH);

    cap_state_e              state_q;
    logic                    rx_read_q, uart_rts_q, irq_q, overrun_q, overrun_d;
    logic [DROP_COUNT_W-1:0] drop_count_q, drop_count_d, cnt_base;
    logic                    capture, full, empty, drop;

    assign capture = state_q == IDLE && rx_valid;
    assign drop    = capture && full && !data_pop;

    uart_rx_fifo #(
        .WIDTH(PAYLOAD_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push_i (capture),
        .data_i (rx_data),
        .pop_i  (data_pop),
        .data_o (data_out),
        .full_o (full),
        .empty_o(empty),
        .level_o(fifo_level)
    );

    // a drop coinciding with a clear restarts the count at one
    always_comb begin
        cnt_base     = clr_overrun ? '0 : drop_count_q;
        drop_count_d = drop ? (cnt_base == '1 ? cnt_base : cnt_base + 1'b1) : cnt_base;
        overrun_d    = drop || (overrun_q && !clr_overrun);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rx_read_q <= 1'b0;
        end else begin
            state_q   <= capture ? ACK : IDLE;
            rx_read_q <= capture;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun_q    <= 1'b0;
            drop_count_q <= '0;
            uart_rts_q   <= 1'b1;
            irq_q        <= 1'b0;
        end else begin
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
            uart_rts_q   <= rx_rts || fifo_level >= LW'(RTS_THRESHOLD);
            irq_q        <= irq_en && (!empty || overrun_q);
        end
    end

    assign rx_read    = rx_read_q;
    assign uart_rts   = uart_rts_q;
    assign data_avail = !empty;
    assign overrun    = overrun_q;
    assign drop_count = drop_count_q;
    assign irq        = irq_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between the `uart_rx` deserialiser and the peripheral register bus. It acknowledges each received byte with a one-cycle `rx_read` pulse and buffers bytes in a small FIFO. It also drives the active-low RTS line from the receiver state and the FIFO fill level, flags overruns, and raises a level interrupt for the CPU. It is the only block allowed to drive the receiver's read handshake.

## Interface
Parameters:
- `PAYLOAD_BITS`, 8: data bits per byte; must match the receiver.
- `FIFO_DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `RTS_THRESHOLD`, `FIFO_DEPTH-1`: RTS deasserts (goes high) when level ≥ this value.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `rx_valid`  in  1  receiver holds a byte.
- `rx_data`  in  `PAYLOAD_BITS`  receiver byte; stable while `rx_valid`.
- `rx_rts`  in  1  receiver's own RTS (1 = busy).
- `rx_read`  out  1  one-cycle acknowledge to receiver.
- `uart_rts`  out  1  pin RTS, active low.
- `data_out`  out  `PAYLOAD_BITS`  FIFO head (show-ahead).
- `data_avail`  out  1  level ≠ 0.
- `data_pop`  in  1  bus read of the data register; removes the head.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current occupancy.
- `overrun`  out  1  sticky: a byte was dropped.
- `drop_count`  out  8  saturating count of dropped bytes.
- `clr_overrun`  in  1  clears `overrun` and `drop_count`.
- `irq_en`  in  1  interrupt enable.
- `irq`  out  1  registered interrupt.

## Operation
- Capture FSM has two states.
  - `IDLE`: if `rx_valid`, take the byte, then go to `ACK`.
  - `ACK`: `rx_read`=1 for this cycle only, then go unconditionally to `IDLE`.
  - `rx_read` is registered and equals (state == `ACK`).
- Push vs. drop:
  - The byte is pushed if the FIFO is not full, or if it is full and `data_pop` is asserted in the same cycle. In that case the pop frees the slot, the level stays unchanged and the order is preserved.
  - Otherwise the byte is dropped: `overrun` is set and `drop_count` is incremented, saturating at 255.
  - Every received byte is acknowledged, whether pushed or dropped.
- Pop:
  - `data_pop` with level 0 is ignored; no pointer or level change.
  - Push and pop in the same cycle with a non-empty FIFO: the level is unchanged.
- `clr_overrun` in the same cycle as a drop: the drop wins. Result is `overrun`=1, `drop_count`=1.
- `uart_rts` is registered: `rx_rts | (fifo_level >= RTS_THRESHOLD)`.
- `irq` is registered: `irq_en & (data_avail | overrun)`.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. Level is pointer width + 1 bits. Full means level == `FIFO_DEPTH`.

## Timing
- Reset values:
  - FSM = `IDLE`; `rx_read`=0; pointers and level = 0; `data_avail`=0.
  - `overrun`=0; `drop_count`=0; `irq`=0; `uart_rts`=1.
  - `data_out` is undefined (X permitted) while empty.
- Reset mid-operation (including while in `ACK`): the FIFO contents are discarded and `rx_read` is low the next cycle.
- Cycle sequence for one received byte:
  - Cycle N: `rx_valid` is seen in `IDLE`; the push happens on edge N.
  - Cycle N+1: `rx_read`=1, `data_avail`=1, the level is updated.
  - Cycle N+2: `irq` and `uart_rts` reflect the new level.
- The receiver drops `rx_valid` one cycle after `rx_read`. Since `ACK` always returns to `IDLE`, a byte is never captured twice.
- Minimum spacing between captures is 2 cycles.
- Pop takes effect on the clock edge; `data_out` shows the next entry one cycle later.

## Structure
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO with parameters `WIDTH` and `DEPTH`. It has push, pop, full, empty and level, and no reset of the storage array.
- Shared UART header holds:
  - FSM state encodings (`IDLE`=0, `ACK`=1);
  - the `DROP_COUNT_W`=8 constant;
  - the level-width helper.
- The controller contains the FSM, the overrun/drop counter and the RTS/IRQ registers; target roughly 150–250 lines total.

## Test plan
- **Single byte.** Send 0xA5 with `rx_valid`. Expect:
  - `rx_read` high for exactly 1 cycle, one cycle after `rx_valid` is first seen;
  - `data_out`=0xA5, `fifo_level`=1;
  - `irq`=1 when `irq_en`=1.
- **Fill and RTS.** `FIFO_DEPTH`=4; push 0x01..0x04. Expect:
  - `uart_rts` rises one cycle after the level reaches 3;
  - pop x4 returns 0x01,0x02,0x03,0x04 in order;
  - `uart_rts` falls again after the level returns to 2.
- **Overrun.** With the FIFO full, push 0x55 and then 0x66. Expect:
  - both bytes acknowledged, `overrun`=1, `drop_count`=2, contents unchanged;
  - `clr_overrun` returns both to 0.
- **Full with simultaneous pop.** With the FIFO full, push 0x77 in the same cycle as `data_pop`. Expect `fifo_level` to stay 4, no overrun, and 0x77 to be the last byte out.
- **Empty pop and saturation.** Pop with level 0: no change. Force 300 drops: `drop_count` holds at 255.
- **Reset mid-operation.** Assert `resetn`=0 during `ACK` with 2 bytes queued. Expect all outputs at their reset values the next cycle.
